// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM block-transfer engine: default widths,
// operation-mode constants and the FSM state encoding.
package ram_dma_pkg;

  localparam int unsigned DefaultAddrW = 14;
  localparam int unsigned DefaultDataW = 16;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFill = 3'd1,
    StRd   = 3'd2,
    StWr   = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/ram_dma_addr_counter.sv
// Word index register for the transfer engine: synchronous clear has priority
// over increment; increments wrap at the register width.
module addr_counter #(
  parameter int unsigned Width = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/ram_dma.sv
// Fill/copy DMA engine driving the write port of a RAM with combinational read.
// Copy alternates one read cycle and one write cycle per word, ascending order.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ADDR_W-1:0] idx;
  logic              idx_clr;
  logic              idx_inc;
  logic              load_raw;
  logic              last_word;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] wr_data;

  addr_counter #(
    .Width(ADDR_W)
  ) u_idx (
    .clk_i(clock),
    .rst_i(reset),
    .clr_i(idx_clr),
    .inc_i(idx_inc),
    .q_o  (idx)
  );

  // Carry out of the add is dropped so regions wrap around the top of memory.
  assign src_addr  = src_q + idx;
  assign dst_addr  = dst_q + idx;
  assign last_word = (idx == (count_q - One));
  assign wr_data   = (mode_q == MODE_FILL) ? fill_q : data_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    count_d     = count_q;
    fill_d      = fill_q;
    data_d      = data_q;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    load_raw    = 1'b0;
    mem_address = '0;
    mem_in      = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src;
          dst_d   = dst;
          count_d = count;
          fill_d  = fill_value;
          idx_clr = 1'b1;
          if (count == '0) begin
            state_d = StDone;
          end else if (mode == MODE_COPY) begin
            state_d = StRd;
          end else begin
            state_d = StFill;
          end
        end
      end
      StFill: begin
        busy        = 1'b1;
        mem_address = dst_addr;
        mem_in      = wr_data;
        load_raw    = 1'b1;
        idx_inc     = 1'b1;
        if (last_word) begin
          state_d = StDone;
        end
      end
      StRd: begin
        busy        = 1'b1;
        mem_address = src_addr;
        data_d      = mem_out;
        state_d     = StWr;
      end
      StWr: begin
        busy        = 1'b1;
        mem_address = dst_addr;
        mem_in      = wr_data;
        load_raw    = 1'b1;
        idx_inc     = 1'b1;
        state_d     = last_word ? StDone : StRd;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // No RAM write may happen on an edge where reset is sampled high.
  assign mem_load = load_raw & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= MODE_FILL;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: a 16K-word RAM, a per-cycle transaction model with a
// shadow memory, and directed fill/copy/abort scenarios.
module tb_ram_dma;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int Words = 16384;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] count = '0;
  logic [DW-1:0] fill_value = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_load;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;

  always #2 clock = ~clock;

  ram_dma #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src        (src),
    .dst        (dst),
    .count      (count),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_load   (mem_load),
    .mem_in     (mem_in),
    .mem_out    (mem_out)
  );

  // RAM16K: combinational read, write on the rising edge.
  logic [DW-1:0] ram [Words];
  logic          init = 1'b1;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  assign mem_out = ram[mem_address];

  always @(posedge clock) begin
    if (init) begin
      for (int i = 0; i < Words; i++) ram[i] <= DW'(i) ^ 16'hA5A5;
    end else begin
      if (mem_load) ram[mem_address] <= mem_in;
      if (pre_we) ram[pre_addr] <= pre_data;
    end
  end

  typedef struct {
    logic          busy;
    logic          done;
    logic          load;
    logic          chk_addr;
    logic          is_rd;
    logic          use_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model_mem [Words];
  logic [DW-1:0] model_rd = '0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            c0 = 0;
  int            n_busy = 0;
  int            n_done = 0;
  int            n_wr = 0;
  int            last_done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic l, input logic ca,
                              input logic rd, input logic ur, input logic [AW-1:0] a,
                              input logic [DW-1:0] v);
    exp_t e;
    e.busy = b; e.done = d; e.load = l; e.chk_addr = ca;
    e.is_rd = rd; e.use_rd = ur; e.addr = a; e.data = v;
    return e;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (busy) n_busy++;
    if (mem_load) n_wr++;
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
    end
  end

  // Per-cycle compare against the transaction model; idle outputs when nothing is queued.
  exp_t e;
  always @(negedge clock) begin
    if (init) begin
      for (int i = 0; i < Words; i++) model_mem[i] = DW'(i) ^ 16'hA5A5;
    end
    if (pre_we) model_mem[pre_addr] = pre_data;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (reset) e.load = 1'b0;
      if (e.use_rd) e.data = model_rd;
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("mem_load", 32'(mem_load), 32'(e.load));
      if (e.chk_addr) chk("mem_address", 32'(mem_address), 32'(e.addr));
      if (e.load) begin
        chk("mem_in", 32'(mem_in), 32'(e.data));
        model_mem[e.addr] = e.data;
      end
      if (e.is_rd) model_rd = model_mem[e.addr];
      if (reset) q.delete();
    end else begin
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle done", 32'(done), 32'd0);
      chk("idle mem_load", 32'(mem_load), 32'd0);
      chk("idle mem_address", 32'(mem_address), 32'd0);
      chk("idle mem_in", 32'(mem_in), 32'd0);
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clock); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < Words; i++) if (ram[i] !== model_mem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  int b0, d0, w0, done_rel;

  task automatic xfer(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [AW-1:0] n, input logic [DW-1:0] fv,
                      input int restart_at, input int reset_at);
    int limit;
    @(posedge clock); #1;
    mode = m; src = s; dst = d; count = n; fill_value = fv; start = 1'b1;
    c0 = cyc; b0 = n_busy; d0 = n_done; w0 = n_wr;
    @(negedge clock); #1;
    for (int k = 0; k < int'(n); k++) begin
      if (m) begin
        q.push_back(mk(1, 0, 0, 1, 1, 0, AW'(s + AW'(k)), '0));
        q.push_back(mk(1, 0, 1, 1, 0, 1, AW'(d + AW'(k)), '0));
      end else begin
        q.push_back(mk(1, 0, 1, 1, 0, 0, AW'(d + AW'(k)), fv));
      end
    end
    q.push_back(mk(0, 1, 0, 0, 0, 0, '0, '0));
    limit = 2 * int'(n) + 6;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        mode = 1'($urandom_range(0, 1));
        src = AW'($urandom); dst = AW'($urandom);
        count = AW'($urandom); fill_value = DW'($urandom);
      end
      start = (k == restart_at);
      reset = (k == reset_at);
      if (q.size() == 0) break;
    end
    start = 1'b0;
    reset = 1'b0;
    if (q.size() != 0) begin
      chk("transfer timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    done_rel = last_done_cyc - c0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    init = 1'b0;
    reset = 1'b0;

    // Fill dst=5, count=3, value 7
    xfer(1'b0, 14'd0, 14'd5, 14'd3, 16'd7, 0, 0);
    chk("t1 ram5", 32'(ram[5]), 32'd7);
    chk("t1 ram6", 32'(ram[6]), 32'd7);
    chk("t1 ram7", 32'(ram[7]), 32'd7);
    chk("t1 ram4 kept", 32'(ram[4]), 32'hA5A1);
    chk("t1 ram8 kept", 32'(ram[8]), 32'hA5AD);
    chk("t1 busy cycles", 32'(n_busy - b0), 32'd3);
    chk("t1 done cycle", 32'(done_rel), 32'd4);
    mem_check("t1 memory");

    // Copy 100..103 -> 200..203
    for (int i = 0; i < 4; i++) preload(AW'(100 + i), DW'(i + 1));
    xfer(1'b1, 14'd100, 14'd200, 14'd4, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) chk("t2 copied word", 32'(ram[200 + i]), 32'(i + 1));
    chk("t2 busy cycles", 32'(n_busy - b0), 32'd8);
    chk("t2 done cycle", 32'(done_rel), 32'd9);
    mem_check("t2 memory");

    // Fill crossing the top of memory
    xfer(1'b0, 14'd0, 14'd16382, 14'd4, 16'd9, 0, 0);
    chk("t3 ram16382", 32'(ram[16382]), 32'd9);
    chk("t3 ram16383", 32'(ram[16383]), 32'd9);
    chk("t3 ram0", 32'(ram[0]), 32'd9);
    chk("t3 ram1", 32'(ram[1]), 32'd9);
    chk("t3 ram2 kept", 32'(ram[2]), 32'hA5A7);
    mem_check("t3 memory");

    // count=0 no-op, then a 5-word fill with a stray start mid-transfer
    xfer(1'b0, 14'd0, 14'd0, 14'd0, 16'h0, 0, 0);
    chk("t4 zero done cycle", 32'(done_rel), 32'd1);
    chk("t4 zero busy", 32'(n_busy - b0), 32'd0);
    chk("t4 zero writes", 32'(n_wr - w0), 32'd0);
    xfer(1'b0, 14'd0, 14'd300, 14'd5, 16'h0055, 2, 0);
    chk("t4 writes", 32'(n_wr - w0), 32'd5);
    chk("t4 dones", 32'(n_done - d0), 32'd1);
    mem_check("t4 memory");

    // Fill of 10 words aborted by reset in cycle 4
    xfer(1'b0, 14'd0, 14'd0, 14'd10, 16'd3, 0, 4);
    chk("t5 ram0", 32'(ram[0]), 32'd3);
    chk("t5 ram1", 32'(ram[1]), 32'd3);
    chk("t5 ram2", 32'(ram[2]), 32'd3);
    chk("t5 ram3 kept", 32'(ram[3]), 32'hA5A6);
    chk("t5 ram4 kept", 32'(ram[4]), 32'hA5A1);
    chk("t5 ram5 kept", 32'(ram[5]), 32'd7);
    chk("t5 ram8 kept", 32'(ram[8]), 32'hA5AD);
    chk("t5 ram9 kept", 32'(ram[9]), 32'hA5AC);
    chk("t5 writes", 32'(n_wr - w0), 32'd3);
    chk("t5 dones", 32'(n_done - d0), 32'd0);
    mem_check("t5 memory");

    // Forward-overlapping copy propagates the first word
    preload(14'd10, 16'd5);
    for (int i = 11; i < 14; i++) preload(AW'(i), 16'd0);
    xfer(1'b1, 14'd10, 14'd11, 14'd3, 16'h0, 0, 0);
    chk("t6 ram11", 32'(ram[11]), 32'd5);
    chk("t6 ram12", 32'(ram[12]), 32'd5);
    chk("t6 ram13", 32'(ram[13]), 32'd5);
    mem_check("t6 memory");

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
